// File: rtl/product_accumulator.sv
// product_accumulator: sums a valid/ready stream of 16-bit products into one
// saturated result per frame, closed by in_last or by reaching MAX_LEN beats.
module product_accumulator #(
    parameter int ACC_W   = 24,
    parameter int MAX_LEN = 256,
    parameter int CNT_W   = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_product,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    typedef enum logic {S_ACCUM, S_EMIT} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_live;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sat;
    logic               w_take;
    logic               w_close;
    logic [ACC_W:0]     w_sum;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_sat_nxt;

    // One spare bit catches the carry out; a carry clamps the sum and marks the frame.
    assign w_take    = r_live && (r_state == S_ACCUM) && in_valid;
    assign w_sum     = {1'b0, r_acc} + {{(ACC_W - 15){1'b0}}, in_product};
    assign w_acc_nxt = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
    assign w_sat_nxt = r_sat | w_sum[ACC_W];
    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_close   = w_take && (in_last || (w_cnt_nxt == CNT_W'(MAX_LEN)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_ACCUM;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = (r_state == S_EMIT) ? (out_ready ? S_ACCUM : S_EMIT)
                                          : (w_close ? S_EMIT : S_ACCUM);
    end

    // r_live keeps the input closed until the first edge after reset release.
    always_comb begin
        in_ready  = r_live && (r_state == S_ACCUM);
        out_valid = (r_state == S_EMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_sat  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_take) begin
                r_acc <= w_acc_nxt;
                r_cnt <= w_cnt_nxt;
                r_sat <= w_sat_nxt;
            end else if (r_state == S_EMIT && out_ready) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_sat <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else if (w_close) begin
            out_sum   <= w_acc_nxt;
            out_count <= w_cnt_nxt;
            out_sat   <= w_sat_nxt;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed and random frames on a default instance and
// a narrow instance (ACC_W=17, MAX_LEN=4), checked against a frame-level model.
module tb_product_accumulator;

    localparam int W0 = 24, L0 = 256, C0 = 9;
    localparam int W1 = 17, L1 = 4,   C1 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid [2];
    logic in_last [2];
    logic out_ready [2];
    logic in_ready [2];
    logic out_valid [2];
    logic out_sat [2];
    logic [15:0] in_product [2];
    logic [W0-1:0] sum0;
    logic [W1-1:0] sum1;
    logic [C0-1:0] cnt0;
    logic [C1-1:0] cnt1;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    product_accumulator #(.ACC_W(W0), .MAX_LEN(L0), .CNT_W(C0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_product(in_product[0]), .in_last(in_last[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sum(sum0), .out_count(cnt0), .out_sat(out_sat[0])
    );

    product_accumulator #(.ACC_W(W1), .MAX_LEN(L1), .CNT_W(C1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_product(in_product[1]), .in_last(in_last[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sum(sum1), .out_count(cnt1), .out_sat(out_sat[1])
    );

    function automatic longint maxv(input int k);
        return k ? (longint'(1) << W1) - 1 : (longint'(1) << W0) - 1;
    endfunction

    function automatic int maxl(input int k);
        return k ? L1 : L0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame-level model: exact unbounded sum, clamped only when the frame is reported.
    longint m_acc [2];
    int     m_cnt [2];
    bit     m_live [2];
    bit     m_emit [2];
    longint e_sum [2];
    int     e_cnt [2];
    bit     e_sat [2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_acc[k] = 0; m_cnt[k] = 0; m_live[k] = 0; m_emit[k] = 0;
                e_sum[k] = 0; e_cnt[k] = 0; e_sat[k] = 0;
            end else begin
                if (m_emit[k]) begin
                    if (out_ready[k]) begin
                        m_emit[k] = 0; m_acc[k] = 0; m_cnt[k] = 0;
                    end
                end else if (m_live[k] && in_valid[k]) begin
                    m_acc[k] += longint'(in_product[k]);
                    m_cnt[k]++;
                    if (in_last[k] || m_cnt[k] == maxl(k)) begin
                        m_emit[k] = 1;
                        e_sat[k]  = m_acc[k] > maxv(k);
                        e_sum[k]  = e_sat[k] ? maxv(k) : m_acc[k];
                        e_cnt[k]  = m_cnt[k];
                    end
                end
                m_live[k] = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready0",  64'(in_ready[0]),  64'(m_live[0] && !m_emit[0]));
        chk("out_valid0", 64'(out_valid[0]), 64'(m_emit[0]));
        chk("out_sum0",   64'(sum0),         64'(e_sum[0]));
        chk("out_count0", 64'(cnt0),         64'(e_cnt[0]));
        chk("out_sat0",   64'(out_sat[0]),   64'(e_sat[0]));
        chk("in_ready1",  64'(in_ready[1]),  64'(m_live[1] && !m_emit[1]));
        chk("out_valid1", 64'(out_valid[1]), 64'(m_emit[1]));
        chk("out_sum1",   64'(sum1),         64'(e_sum[1]));
        chk("out_count1", 64'(cnt1),         64'(e_cnt[1]));
        chk("out_sat1",   64'(out_sat[1]),   64'(e_sat[1]));
    end

    // Present one beat and hold it until the DUT takes it; returns 1 time unit after the accepting edge.
    task automatic send(input int k, input logic [15:0] p, input logic l, input bit rnd);
        in_valid[k] = 1'b1; in_product[k] = p; in_last[k] = l;
        for (int i = 0; ; i++) begin
            @(negedge clk);
            if (in_ready[k]) break;
            if (i == 100) begin
                chk("send_timeout", 64'(in_ready[k]), 64'd1);
                break;
            end
            if (rnd) out_ready[k] = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1 in_valid[k] = 1'b0; in_last[k] = 1'b0;
    endtask

    initial begin
        in_valid = '{1'b0, 1'b0}; in_last = '{1'b0, 1'b0};
        out_ready = '{1'b1, 1'b1}; in_product = '{16'd0, 16'd0};
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 chk("ready_before_edge", 64'(in_ready[0]), 64'd0);
        @(posedge clk);
        #1 chk("ready_after_edge", 64'(in_ready[0]), 64'd1);

        // Basic frame 6+20+65025
        send(0, 16'd6, 1'b0, 1'b0);
        send(0, 16'd20, 1'b0, 1'b0);
        send(0, 16'd65025, 1'b1, 1'b0);
        chk("t2_valid", 64'(out_valid[0]), 64'd1);
        chk("t2_sum",   64'(sum0),         64'd65051);
        chk("t2_count", 64'(cnt0),         64'd3);
        chk("t2_sat",   64'(out_sat[0]),   64'd0);
        @(posedge clk);
        #1 chk("t2_ready", 64'(in_ready[0]), 64'd1);

        // Backpressure: the result holds while a waiting beat stays unconsumed
        out_ready[0] = 1'b0;
        send(0, 16'd6, 1'b0, 1'b0);
        send(0, 16'd20, 1'b0, 1'b0);
        send(0, 16'd65025, 1'b1, 1'b0);
        in_valid[0] = 1'b1; in_product[0] = 16'd99; in_last[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t3_hold_valid", 64'(out_valid[0]), 64'd1);
            chk("t3_hold_sum",   64'(sum0),         64'd65051);
            chk("t3_hold_ready", 64'(in_ready[0]),  64'd0);
        end
        out_ready[0] = 1'b1;
        send(0, 16'd99, 1'b1, 1'b0);
        chk("t3_next_sum",   64'(sum0), 64'd99);
        chk("t3_next_count", 64'(cnt0), 64'd1);

        // Forced close at MAX_LEN=4 on the narrow instance
        out_ready[1] = 1'b0;
        repeat (4) send(1, 16'd100, 1'b0, 1'b0);
        chk("t4_valid", 64'(out_valid[1]), 64'd1);
        chk("t4_sum",   64'(sum1),         64'd400);
        chk("t4_count", 64'(cnt1),         64'd4);
        out_ready[1] = 1'b1;
        send(1, 16'd100, 1'b0, 1'b0);
        send(1, 16'd100, 1'b1, 1'b0);
        chk("t4b_sum",   64'(sum1), 64'd200);
        chk("t4b_count", 64'(cnt1), 64'd2);

        // Saturation at ACC_W=17, then a clean frame
        send(1, 16'd65025, 1'b0, 1'b0);
        send(1, 16'd65025, 1'b0, 1'b0);
        send(1, 16'd65025, 1'b1, 1'b0);
        chk("t5_sum",   64'(sum1),       64'd131071);
        chk("t5_sat",   64'(out_sat[1]), 64'd1);
        chk("t5_count", 64'(cnt1),       64'd3);
        send(1, 16'd5, 1'b1, 1'b0);
        chk("t5b_sum", 64'(sum1),       64'd5);
        chk("t5b_sat", 64'(out_sat[1]), 64'd0);

        // Reset mid-frame discards the partial sum
        send(0, 16'd1000, 1'b0, 1'b0);
        send(0, 16'd1000, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("t6_valid_rst", 64'(out_valid[0]), 64'd0);
        chk("t6_ready_rst", 64'(in_ready[0]), 64'd0);
        chk("t6_sum_rst",   64'(sum0),        64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        send(0, 16'd7, 1'b1, 1'b0);
        chk("t6_valid", 64'(out_valid[0]), 64'd1);
        chk("t6_sum",   64'(sum0),         64'd7);
        chk("t6_count", 64'(cnt0),         64'd1);

        // Random frames with random backpressure on both instances
        for (int n = 0; n < 300; n++) begin
            int k;
            logic [15:0] p;
            k = int'($urandom_range(0, 1));
            p = k ? 16'($urandom_range(60000, 65535)) : 16'($urandom);
            if ($urandom_range(0, 7) == 0) p = 16'd0;
            send(k, p, 1'($urandom_range(0, 5) == 0), 1'b1);
        end
        out_ready = '{1'b1, 1'b1};
        repeat (5) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
